// File: rtl/jacobi_iter_ctrl.sv
// Iteration controller for the two-lane digit-serial Jacobi core: feeds x0/x1 MSD-first,
// collects the core's output digits and loops them back for a commanded number of iterations.
module jacobi_iter_ctrl #(
  parameter int DIGITS = 16,
  parameter int ITER_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cmd_start,
  input  logic [ITER_W-1:0]   cmd_iters,
  input  logic                cmd_abort,
  input  logic [2*DIGITS-1:0] x0_init,
  input  logic [2*DIGITS-1:0] x1_init,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ITER_W-1:0]   iter_cnt,
  output logic [2*DIGITS-1:0] res_x0,
  output logic [2*DIGITS-1:0] res_x1,
  output logic [2:0]          start_in_0,
  output logic                start_valid_0,
  input  logic                start_ready_0,
  output logic [2:0]          start_in_1,
  output logic                start_valid_1,
  input  logic                start_ready_1,
  input  logic [2:0]          end_out_0,
  input  logic                end_valid_0,
  output logic                end_ready_0,
  input  logic [2:0]          end_out_1,
  input  logic                end_valid_1,
  output logic                end_ready_1
);

  localparam int VW    = 2 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_UPDATE, S_DONE} state_t;

  state_t            r_state;
  logic [ITER_W-1:0] r_iters;
  logic [VW-1:0]     r_feed     [2];
  logic [VW-1:0]     r_col      [2];
  logic [IDX_W-1:0]  r_feed_idx [2];
  logic [IDX_W-1:0]  r_col_idx  [2];
  logic [1:0]        r_sv;
  logic [1:0]        r_fed;
  logic [1:0]        r_colled;

  logic              w_run;
  logic              w_end_rdy;
  logic [1:0]        w_ready;
  logic [1:0]        w_ev;
  logic [2:0]        w_end [2];
  logic [1:0]        w_feed_acc;
  logic [1:0]        w_feed_last;
  logic [1:0]        w_col_acc;
  logic [1:0]        w_col_last;
  logic [1:0]        w_len_err;
  logic [1:0]        w_fed_n;
  logic [1:0]        w_colled_n;
  logic [ITER_W-1:0] w_iter_next;

  assign w_run       = (r_state == S_RUN);
  assign w_end_rdy   = (r_state == S_IDLE) || w_run;
  assign w_ready     = {start_ready_1, start_ready_0};
  assign w_ev        = {end_valid_1, end_valid_0};
  assign w_end[0]    = end_out_0;
  assign w_end[1]    = end_out_1;
  assign w_iter_next = iter_cnt + ITER_W'(1);

  assign start_in_0    = {r_feed_idx[0] == LAST_IDX, r_feed[0][VW-1 -: 2]};
  assign start_in_1    = {r_feed_idx[1] == LAST_IDX, r_feed[1][VW-1 -: 2]};
  assign start_valid_0 = r_sv[0];
  assign start_valid_1 = r_sv[1];
  assign end_ready_0   = w_end_rdy;
  assign end_ready_1   = w_end_rdy;

  // "Next" fed/collected flags let RUN leave on the very cycle the final last digit lands.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_feed_acc  = '0;
    w_feed_last = '0;
    w_col_acc   = '0;
    w_col_last  = '0;
    w_len_err   = '0;
    for (int l = 0; l < 2; l++) begin
      w_feed_acc[l]  = w_run & r_sv[l] & w_ready[l];
      w_feed_last[l] = w_feed_acc[l] & (r_feed_idx[l] == LAST_IDX);
      w_col_acc[l]   = w_run & w_ev[l];
      w_col_last[l]  = w_col_acc[l] & w_end[l][2];
      w_len_err[l]   = w_col_acc[l] & ((r_col_idx[l] >= FULL_IDX) |
                                       (w_end[l][2] & (r_col_idx[l] != LAST_IDX)));
    end
    w_fed_n    = r_fed | w_feed_last;
    w_colled_n = r_colled | w_col_last;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_iters  <= '0;
      r_sv     <= '0;
      r_fed    <= '0;
      r_colled <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      iter_cnt <= '0;
      res_x0   <= '0;
      res_x1   <= '0;
      // NOTE: the vector arrays are plain flops, not RAM, so they take the reset like any other state.
      for (int l = 0; l < 2; l++) begin
        r_feed[l]     <= '0;
        r_col[l]      <= '0;
        r_feed_idx[l] <= '0;
        r_col_idx[l]  <= '0;
      end
    end else begin
      done <= 1'b0;
      if (cmd_abort && (r_state == S_RUN || r_state == S_UPDATE)) begin
        r_sv    <= '0;
        busy    <= 1'b0;
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cmd_start && !cmd_abort) begin
              r_iters  <= cmd_iters;
              iter_cnt <= '0;
              err      <= 1'b0;
              r_fed    <= '0;
              r_colled <= '0;
              for (int l = 0; l < 2; l++) begin
                r_col[l]      <= '0;
                r_feed_idx[l] <= '0;
                r_col_idx[l]  <= '0;
              end
              if (cmd_iters == '0) begin
                res_x0  <= x0_init;
                res_x1  <= x1_init;
                done    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_feed[0] <= x0_init;
                r_feed[1] <= x1_init;
                r_sv      <= 2'b11;
                busy      <= 1'b1;
                r_state   <= S_RUN;
              end
            end
          end

          S_RUN: begin
            for (int l = 0; l < 2; l++) begin
              if (w_feed_acc[l]) begin
                r_feed_idx[l] <= r_feed_idx[l] + IDX_W'(1);
                r_feed[l]     <= {r_feed[l][VW-3:0], 2'b00};
                if (w_feed_last[l]) r_sv[l] <= 1'b0;
              end
              if (w_col_acc[l]) begin
                for (int k = 0; k < DIGITS; k++) begin
                  if (r_col_idx[l] == IDX_W'(k)) r_col[l][VW-1-2*k -: 2] <= w_end[l][1:0];
                end
                // Saturate so overlong streams keep flagging instead of wrapping onto digit 0.
                if (r_col_idx[l] != FULL_IDX) r_col_idx[l] <= r_col_idx[l] + IDX_W'(1);
              end
            end
            r_fed    <= w_fed_n;
            r_colled <= w_colled_n;
            if (|w_len_err) err <= 1'b1;
            if (&w_colled_n) begin
              r_sv    <= '0;
              r_state <= S_UPDATE;
              if (!(&w_fed_n)) err <= 1'b1;
            end
          end

          S_UPDATE: begin
            r_feed[0] <= r_col[0];
            r_feed[1] <= r_col[1];
            res_x0    <= r_col[0];
            res_x1    <= r_col[1];
            iter_cnt  <= w_iter_next;
            r_fed     <= '0;
            r_colled  <= '0;
            for (int l = 0; l < 2; l++) begin
              r_col[l]      <= '0;
              r_feed_idx[l] <= '0;
              r_col_idx[l]  <= '0;
            end
            if (w_iter_next == r_iters) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_sv    <= 2'b11;
              r_state <= S_RUN;
            end
          end

          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jacobi_iter_ctrl.sv
// Bench for jacobi_iter_ctrl: 3-cycle echo stub core, a vector-level model of the expected
// feed streams and results, a per-cycle compare process and directed literal checks.
module tb_jacobi_iter_ctrl;
  localparam int DIGITS = 16;
  localparam int VW     = 2 * DIGITS;

  localparam logic [VW-1:0] X0 = 32'h6666_6666;  // alternating 01/10
  localparam logic [VW-1:0] X1 = 32'h5555_5555;  // all 01

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_start, cmd_abort;
  logic [7:0]    cmd_iters;
  logic [VW-1:0] x0_init, x1_init;
  logic          busy, done, err;
  logic [7:0]    iter_cnt;
  logic [VW-1:0] res_x0, res_x1;
  logic [2:0]    start_in_0, start_in_1;
  logic          start_valid_0, start_valid_1;
  logic          start_ready_0 = 1'b1, start_ready_1 = 1'b1;
  logic [2:0]    end_out_0 = '0, end_out_1 = '0;
  logic          end_valid_0 = 1'b0, end_valid_1 = 1'b0;
  logic          end_ready_0, end_ready_1;

  always #5 clk = ~clk;

  jacobi_iter_ctrl #(.DIGITS(DIGITS), .ITER_W(8)) dut (
    .clk(clk), .rstn(rstn), .cmd_start(cmd_start), .cmd_iters(cmd_iters), .cmd_abort(cmd_abort),
    .x0_init(x0_init), .x1_init(x1_init), .busy(busy), .done(done), .err(err),
    .iter_cnt(iter_cnt), .res_x0(res_x0), .res_x1(res_x1),
    .start_in_0(start_in_0), .start_valid_0(start_valid_0), .start_ready_0(start_ready_0),
    .start_in_1(start_in_1), .start_valid_1(start_valid_1), .start_ready_1(start_ready_1),
    .end_out_0(end_out_0), .end_valid_0(end_valid_0), .end_ready_0(end_ready_0),
    .end_out_1(end_out_1), .end_valid_1(end_valid_1), .end_ready_1(end_ready_1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected behaviour, computed per run at vector level.
  logic [2:0]    exp_q0[$], exp_q1[$];
  logic [VW-1:0] exp_res0, exp_res1;
  logic [7:0]    exp_it;
  logic          exp_err;
  bit            trunc0 = 0, tog0 = 0;

  function automatic logic [1:0] dig(input logic [VW-1:0] v, input int k);
    return v[VW-1-2*k -: 2];
  endfunction

  task automatic build_model(input logic [7:0] it, input logic [VW-1:0] a, input logic [VW-1:0] b,
                             input bit tr);
    logic [VW-1:0] c0, c1;
    c0 = a;
    c1 = b;
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < int'(it); i++) begin
      for (int k = 0; k < DIGITS; k++) begin
        exp_q0.push_back({k == DIGITS - 1, dig(c0, k)});
        exp_q1.push_back({k == DIGITS - 1, dig(c1, k)});
      end
      // The stub ends lane 0 one digit early, so the final digit reads back as 00.
      if (tr) c0[1:0] = 2'b00;
    end
    exp_res0 = c0;
    exp_res1 = c1;
    exp_it   = it;
    exp_err  = tr;
  endtask

  // Stub core: echoes every accepted digit three cycles later.
  logic [3:0] p0[3], p1[3];
  int         sidx0 = 0, sidx1 = 0;
  logic       s_t0, s_t1, s_busy, s_rstn;
  logic [2:0] s_d0, s_d1;
  logic [3:0] nd0, nd1;

  initial for (int i = 0; i < 3; i++) begin p0[i] = '0; p1[i] = '0; end

  always @(posedge clk) begin
    s_t0 = start_valid_0 && start_ready_0;
    s_t1 = start_valid_1 && start_ready_1;
    s_d0 = start_in_0;
    s_d1 = start_in_1;
    s_busy = busy;
    s_rstn = rstn;
    #1;
    if (!s_busy) begin sidx0 = 0; sidx1 = 0; end
    nd0 = '0;
    nd1 = '0;
    if (s_t0) begin
      nd0 = {1'b1, s_d0};
      if (trunc0 && sidx0 == DIGITS - 2) nd0[2] = 1'b1;
      if (trunc0 && sidx0 == DIGITS - 1) nd0 = '0;
      sidx0 = s_d0[2] ? 0 : sidx0 + 1;
    end
    if (s_t1) begin
      nd1 = {1'b1, s_d1};
      sidx1 = s_d1[2] ? 0 : sidx1 + 1;
    end
    p0[2] = p0[1]; p0[1] = p0[0]; p0[0] = nd0;
    p1[2] = p1[1]; p1[1] = p1[0]; p1[0] = nd1;
    if (!s_rstn) for (int i = 0; i < 3; i++) begin p0[i] = '0; p1[i] = '0; end
    end_valid_0 = p0[2][3];
    end_out_0   = p0[2][2:0];
    end_valid_1 = p1[2][3];
    end_out_1   = p1[2][2:0];
    start_ready_0 = tog0 ? ~start_ready_0 : 1'b1;
  end

  // Compare process: every accepted feed digit, stall stability, and the done-cycle results.
  int         acc0 = 0, acc1 = 0, done_cnt = 0, sv_cnt = 0;
  logic       st0 = 0, st1 = 0;
  logic [2:0] hold0, hold1;

  always @(negedge clk) begin
    if (!rstn) begin
      st0 = 0;
      st1 = 0;
    end else begin
      if (st0) begin
        check("stall_valid_0", start_valid_0, 1);
        check("stall_payload_0", start_in_0, hold0);
      end
      if (st1) begin
        check("stall_valid_1", start_valid_1, 1);
        check("stall_payload_1", start_in_1, hold1);
      end
      st0 = start_valid_0 && !start_ready_0;
      st1 = start_valid_1 && !start_ready_1;
      hold0 = start_in_0;
      hold1 = start_in_1;
      if (start_valid_0 || start_valid_1) sv_cnt++;
      if (start_valid_0 && start_ready_0) begin
        acc0++;
        check("feed_digit_0", {1'b1, start_in_0}, exp_q0.size() > 0 ? {1'b1, exp_q0.pop_front()} : 4'b0);
      end
      if (start_valid_1 && start_ready_1) begin
        acc1++;
        check("feed_digit_1", {1'b1, start_in_1}, exp_q1.size() > 0 ? {1'b1, exp_q1.pop_front()} : 4'b0);
      end
      if (done) begin
        done_cnt++;
        check("done_res_x0", res_x0, exp_res0);
        check("done_res_x1", res_x1, exp_res1);
        check("done_iter_cnt", iter_cnt, exp_it);
        check("done_err", err, exp_err);
        check("done_busy_low", busy, 0);
        check("done_feed_left_0", exp_q0.size(), 0);
        check("done_feed_left_1", exp_q1.size(), 0);
      end
    end
  end

  int base_acc0, base_acc1, base_done, base_sv;

  task automatic start_run(input logic [7:0] it, input logic [VW-1:0] a, input logic [VW-1:0] b,
                           input bit tr);
    build_model(it, a, b, tr);
    trunc0    = tr;
    base_acc0 = acc0;
    base_acc1 = acc1;
    base_done = done_cnt;
    base_sv   = sv_cnt;
    cmd_iters = it;
    x0_init   = a;
    x1_init   = b;
    cmd_start = 1'b1;
    @(posedge clk);
    #1 cmd_start = 1'b0;
    @(negedge clk);
    check("start_err_cleared", err, 0);
    if (it != 0) begin
      check("start_busy", busy, 1);
      check("start_valid_0", start_valid_0, 1);
      check("start_valid_1", start_valid_1, 1);
    end else begin
      check("zero_iter_done", done, 1);
      check("zero_iter_busy", busy, 0);
      check("zero_iter_valid", {start_valid_1, start_valid_0}, 2'b00);
    end
  endtask

  task automatic finish_run(input int exp_acc);
    for (int i = 0; i < 3000; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("done_count", done_cnt - base_done, 1);
    check("accepted_0", acc0 - base_acc0, exp_acc);
    check("accepted_1", acc1 - base_acc1, exp_acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    cmd_iters = '0;
    x0_init = '0;
    x1_init = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_iter_cnt", iter_cnt, 0);
    check("rst_res", {res_x0, res_x1}, 0);
    check("rst_valid", {start_valid_1, start_valid_0}, 2'b00);
    check("rst_end_ready", {end_ready_1, end_ready_0}, 2'b11);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Three identity iterations; a second cmd_start mid-run must be ignored.
    start_run(8'd3, X0, X1, 0);
    repeat (10) @(posedge clk);
    #1;
    cmd_iters = 8'd1;
    x0_init   = '0;
    cmd_start = 1'b1;
    @(posedge clk);
    #1 cmd_start = 1'b0;
    finish_run(48);
    check("t1_res_x0", res_x0, 32'h6666_6666);
    check("t1_res_x1", res_x1, 32'h5555_5555);
    check("t1_iter_cnt", iter_cnt, 3);
    check("t1_err", err, 0);

    // Lane 0 ready toggles every cycle, lane 1 always ready.
    tog0 = 1;
    start_run(8'd3, X0, X1, 0);
    finish_run(48);
    tog0 = 0;
    check("t2_res_x0", res_x0, 32'h6666_6666);
    check("t2_res_x1", res_x1, 32'h5555_5555);

    // Core ends lane 0 at digit 14.
    start_run(8'd3, X0, X1, 1);
    finish_run(48);
    check("t3_res_x0", res_x0, 32'h6666_6664);
    check("t3_res_x1", res_x1, 32'h5555_5555);
    check("t3_err", err, 1);
    trunc0 = 0;

    // Abort during iteration 2, then a clean run.
    start_run(8'd3, X0, X1, 0);
    for (int i = 0; i < 500; i++) begin
      if (iter_cnt == 8'd1) break;
      @(negedge clk);
    end
    check("abort_iter1_reached", iter_cnt, 1);
    repeat (4) @(negedge clk);
    cmd_abort = 1'b1;
    @(posedge clk);
    #1 cmd_abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", {start_valid_1, start_valid_0}, 2'b00);
    check("abort_iter_cnt", iter_cnt, 1);
    check("abort_res_x0", res_x0, 32'h6666_6666);
    check("abort_done", done, 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - base_done, 0);
    check("abort_stays_idle", busy, 0);
    start_run(8'd2, 32'hA5A5_0F0F, 32'h1B1B_E4E4, 0);
    finish_run(32);
    check("post_abort_res_x0", res_x0, 32'hA5A5_0F0F);
    check("post_abort_res_x1", res_x1, 32'h1B1B_E4E4);
    check("post_abort_err", err, 0);

    // Zero iterations: done immediately, no feed at all.
    start_run(8'd0, 32'hDEAD_BEEF, 32'h0123_4567, 0);
    @(negedge clk);
    check("zero_done_pulse", done, 0);
    check("zero_done_count", done_cnt - base_done, 1);
    check("zero_no_valid", sv_cnt - base_sv, 0);
    check("zero_res_x0", res_x0, 32'hDEAD_BEEF);
    check("zero_res_x1", res_x1, 32'h0123_4567);
    check("zero_iter_cnt", iter_cnt, 0);

    // One-cycle reset in the middle of a run.
    start_run(8'd2, X0, X1, 0);
    repeat (8) @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_iter_cnt", iter_cnt, 0);
    check("mid_rst_res", {res_x0, res_x1}, 0);
    check("mid_rst_valid", {start_valid_1, start_valid_0}, 2'b00);
    check("mid_rst_end_ready", {end_ready_1, end_ready_0}, 2'b11);
    repeat (10) @(negedge clk);
    check("mid_rst_no_done", done_cnt - base_done, 0);
    check("mid_rst_idle", busy, 0);
    start_run(8'd1, 32'h3C3C_3C3C, 32'hC3C3_C3C3, 0);
    finish_run(16);
    check("recover_res_x0", res_x0, 32'h3C3C_3C3C);
    check("recover_iter_cnt", iter_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
